// File: rtl/flp_imult_pkg.sv
// Shared types and sizing helpers for the iterative integer multiplier.
// Latency: none (declarations only).
// Backpressure: not applicable.
package flp_imult_pkg;

    // Controller states; encodings are fixed so they can be probed from outside.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } imult_state_e;

    // Number of multiply iterations for one operand pair.
    function automatic int imult_nsteps(input int width, input int step);
        return width / step;
    endfunction

    // Iteration counter width: wide enough to hold NSTEPS itself.
    function automatic int imult_cnt_w(input int width, input int step);
        return $clog2(width / step) + 1;
    endfunction

endpackage

// File: rtl/flp_imult_step.sv
// One shift-and-add iteration: adds STEP partial products into the accumulator.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is registered.
module flp_imult_step
    import flp_imult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 8
) (
    input  logic [STEP-1:0]    mlpr_bits_i,
    input  logic [2*WIDTH-1:0] mlpd_i,
    input  logic [2*WIDTH-1:0] acc_i,
    output logic [2*WIDTH-1:0] acc_o
);

    // Accumulate the multiplicand shifted by j for every set multiplier bit j.
    always_comb begin
        acc_o = acc_i;
        for (int j = 0; j < STEP; j++) begin
            if (mlpr_bits_i[j]) begin
                acc_o = acc_o + (mlpd_i << j);
            end
        end
    end

endmodule

// File: rtl/flp_imult_seq.sv
// Iterative unsigned WIDTH x WIDTH multiplier retiring STEP multiplier bits per clock.
// Latency: WIDTH/STEP+1 edges accept-to-valid (data dependent when FLP_IMULT_SEQ_EARLY_EXIT_EN is defined).
// Backpressure: product held in DONE until i_ready; o_ready only in IDLE, no accept-while-draining.
module flp_imult_seq
    import flp_imult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WIDTH-1:0]   i_mlpr,
    input  logic [WIDTH-1:0]   i_mlpd,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [2*WIDTH-1:0] o_prod,
    output logic               o_busy
);

    localparam int NSTEPS = imult_nsteps(WIDTH, STEP);
    localparam int CNT_W  = imult_cnt_w(WIDTH, STEP);
    localparam int PW     = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSTEPS - 1);

    imult_state_e     state_q, state_d;
    logic [WIDTH-1:0] mlpr_q, mlpr_d;
    logic [PW-1:0]    mlpd_q, mlpd_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [PW-1:0]    acc_nxt;
    logic [WIDTH-1:0] mlpr_shift;
    logic             last_step;
    logic             mult_exit;
    logic             idle_zero;

    // Low STEP multiplier bits select which shifted multiplicands join this cycle.
    flp_imult_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .mlpr_bits_i (mlpr_q[STEP-1:0]),
        .mlpd_i      (mlpd_q),
        .acc_i       (prod_q),
        .acc_o       (acc_nxt)
    );

    assign mlpr_shift = mlpr_q >> STEP;
    assign last_step  = (cnt_q == CNT_LAST);

`ifdef FLP_IMULT_SEQ_EARLY_EXIT_EN
    // Once no multiplier bits remain the accumulator cannot change, so stop early.
    assign mult_exit = last_step || (mlpr_shift == '0);
    assign idle_zero = (i_mlpr == '0);
`else
    assign mult_exit = last_step;
    assign idle_zero = 1'b0;
`endif

    // State register; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: accept in IDLE, iterate in MULT, hold product in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    state_d = idle_zero ? DONE : MULT;
                end
            end
            MULT: begin
                if (mult_exit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state only, so no input-to-output combinational path.
    always_comb begin
        o_ready = (state_q == IDLE);
        o_valid = (state_q == DONE);
        o_busy  = (state_q != IDLE);
    end

    // Datapath next values: load operands on accept, shift and accumulate while multiplying.
    always_comb begin
        mlpr_d = mlpr_q;
        mlpd_d = mlpd_q;
        prod_d = prod_q;
        cnt_d  = cnt_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    mlpr_d = i_mlpr;
                    mlpd_d = {{WIDTH{1'b0}}, i_mlpd};
                    prod_d = '0;
                    cnt_d  = '0;
                end
            end
            MULT: begin
                prod_d = acc_nxt;
                mlpr_d = mlpr_shift;
                mlpd_d = mlpd_q << STEP;
                cnt_d  = cnt_q + CNT_W'(1);
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; the product register is held untouched in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mlpr_q <= '0;
            mlpd_q <= '0;
            prod_q <= '0;
            cnt_q  <= '0;
        end else begin
            mlpr_q <= mlpr_d;
            mlpd_q <= mlpd_d;
            prod_q <= prod_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_prod = prod_q;

endmodule

// File: tb/tb_flp_imult_seq.sv
// Self-checking bench for flp_imult_seq with STEP in {1, 4, 8, 32}, WIDTH = 32.
// Directed steps run on the STEP=8 instance; random back-to-back runs on all four.
// Expected products come from a scoreboard queue filled at operand accept.
module tb_flp_imult_seq;

`ifdef FLP_IMULT_SEQ_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        vld_i [4];
    logic        rdy_i [4];
    logic [31:0] a_i   [4];
    logic [31:0] b_i   [4];
    logic        ordy  [4];
    logic        ovld  [4];
    logic        busy  [4];
    logic [63:0] prod  [4];

    int          errors = 0;
    int          checks = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        flp_imult_seq #(
            .WIDTH (32),
            .STEP  ((k == 0) ? 1 : (k == 1) ? 4 : (k == 2) ? 8 : 32)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .i_valid (vld_i[k]),
            .o_ready (ordy[k]),
            .i_mlpr  (a_i[k]),
            .i_mlpd  (b_i[k]),
            .o_valid (ovld[k]),
            .i_ready (rdy_i[k]),
            .o_prod  (prod[k]),
            .o_busy  (busy[k])
        );
    end

    function automatic int nsteps_of(input int k);
        case (k)
            0:       return 32;
            1:       return 8;
            2:       return 4;
            default: return 1;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait for ready, present one operand pair, then count edges until o_valid.
    task automatic start_op(input int k, input logic [31:0] a, input logic [31:0] b,
                            output int lat, output bit busy_ok);
        int n;
        n = 0;
        while (!ordy[k] && n < 200) begin
            tick();
            n++;
        end
        check("start_ready", 64'(ordy[k]), 64'd1);
        vld_i[k] = 1'b1;
        a_i[k]   = a;
        b_i[k]   = b;
        tick();
        vld_i[k] = 1'b0;
        sb.push_back(64'(a) * 64'(b));
        busy_ok = 1'b1;
        lat = 1;
        while (!ovld[k] && lat < 200) begin
            if (!busy[k]) busy_ok = 1'b0;
            tick();
            lat++;
        end
        if (!busy[k]) busy_ok = 1'b0;
    endtask

    // Compare the held product with the scoreboard, then hand it off for one cycle.
    task automatic drain(input int k, input string tag);
        logic [63:0] e;
        e = (sb.size() > 0) ? sb.pop_front() : 64'hxxxx_xxxx_xxxx_xxxx;
        check(tag, prod[k], e);
        rdy_i[k] = 1'b1;
        tick();
        rdy_i[k] = 1'b0;
        check({tag, "_ready_after"}, 64'(ordy[k]), 64'd1);
        check({tag, "_valid_after"}, 64'(ovld[k]), 64'd0);
    endtask

    initial begin
        int          lat;
        bit          bz;
        bit          stable;
        logic [63:0] p0;
        logic [31:0] ra, rb;
        logic [63:0] e;

        for (int k = 0; k < 4; k++) begin
            vld_i[k] = 1'b0;
            rdy_i[k] = 1'b0;
            a_i[k]   = '0;
            b_i[k]   = '0;
        end

        // Reset state, sampled before the first clock edge.
        #2 rst = 1'b1;
        #2;
        check("reset_ready", 64'(ordy[2]), 64'd1);
        check("reset_valid", 64'(ovld[2]), 64'd0);
        check("reset_busy",  64'(busy[2]), 64'd0);
        check("reset_prod",  prod[2],      64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Basic 3 x 5.
        start_op(2, 32'd3, 32'd5, lat, bz);
        check("basic_latency", 64'(lat), EE ? 64'd2 : 64'd5);
        check("basic_busy", 64'(bz), 64'd1);
        check("basic_const", prod[2], 64'd15);
        drain(2, "basic_prod");

        // Max operands, then backpressure in DONE with noisy inputs.
        start_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bz);
        check("max_latency", 64'(lat), 64'd5);
        check("max_const", prod[2], 64'hFFFF_FFFE_0000_0001);
        p0 = prod[2];
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            vld_i[2] = ~vld_i[2];
            a_i[2]   = $urandom;
            b_i[2]   = $urandom;
            tick();
            if (!ovld[2] || prod[2] !== p0 || ordy[2]) stable = 1'b0;
        end
        vld_i[2] = 1'b0;
        check("bp_stable", 64'(stable), 64'd1);
        drain(2, "max_prod");
        check("bp_idle_busy", 64'(busy[2]), 64'd0);

        // Zero multiplier.
        start_op(2, 32'd0, 32'h1234_5678, lat, bz);
        check("zero_latency", 64'(lat), EE ? 64'd1 : 64'd5);
        drain(2, "zero_prod");

        // Asynchronous reset in the middle of an operation (cnt == 2).
        vld_i[2] = 1'b1;
        a_i[2]   = 32'hDEAD_BEEF;
        b_i[2]   = 32'h1234_5678;
        tick();
        vld_i[2] = 1'b0;
        tick();
        tick();
        check("midrst_pre_busy", 64'(busy[2]), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_ready", 64'(ordy[2]), 64'd1);
        check("midrst_valid", 64'(ovld[2]), 64'd0);
        check("midrst_busy",  64'(busy[2]), 64'd0);
        check("midrst_prod",  prod[2],      64'd0);
        #10 rst = 1'b0;
        tick();
        start_op(2, 32'd7, 32'd9, lat, bz);
        check("post_rst_latency", 64'(lat), EE ? 64'd2 : 64'd5);
        check("post_rst_const", prod[2], 64'd63);
        drain(2, "post_rst_prod");

        // Random back-to-back operation with i_ready held high on every STEP variant.
        for (int k = 0; k < 4; k++) begin
            rdy_i[k] = 1'b1;
            for (int i = 0; i < 1000; i++) begin
                ra = $urandom;
                rb = $urandom;
                if (i % 64 == 5) ra = 32'hFFFF_FFFF;
                if (i % 64 == 9) rb = 32'hFFFF_FFFF;
                start_op(k, ra, rb, lat, bz);
                e = (sb.size() > 0) ? sb.pop_front() : 64'hxxxx_xxxx_xxxx_xxxx;
                check("rand_prod", prod[k], e);
                tick();
                lat++;
                if (EE) check("rand_cycles_max", 64'(lat <= nsteps_of(k) + 2), 64'd1);
                else    check("rand_cycles", 64'(lat), 64'(nsteps_of(k) + 2));
            end
            rdy_i[k] = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flp_imult_seq.md
Name: flp_imult_seq

Overview:
- Iterative unsigned integer multiplier controller for the FLP unit.
- Accepts one WIDTH x WIDTH operand pair over a valid/ready handshake.
- Retires STEP multiplier bits per clock through a combinational shift-and-add step sub-module.
- Holds the 2*WIDTH-bit product until the consumer takes it.
- Area-saving alternative to a fully unrolled multiplier chain; feeds mantissa multiply in FP mul.

Parameters:
- WIDTH, 32, operand width in bits.
- STEP, 8, multiplier bits consumed per cycle. Must divide WIDTH exactly; 1 <= STEP <= WIDTH.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- i_valid  input  1  operand pair valid.
- o_ready  output  1  controller can accept operands (state IDLE).
- i_mlpr  input  WIDTH  multiplier.
- i_mlpd  input  WIDTH  multiplicand.
- o_valid  output  1  product valid (state DONE).
- i_ready  input  1  consumer accepts product.
- o_prod  output  2*WIDTH  product, registered.
- o_busy  output  1  state != IDLE.

Behaviour:
- Internal registers:
  - mlpr_r (WIDTH).
  - mlpd_r (2*WIDTH).
  - prod_r (2*WIDTH), drives o_prod.
  - cnt (clog2(NSTEPS)+1 bits), where NSTEPS = WIDTH/STEP.
  - state.
- Reset (async, any time including mid-operation):
  - state = IDLE, prod_r = 0, mlpr_r = 0, mlpd_r = 0, cnt = 0.
  - Outputs: o_ready = 1, o_valid = 0, o_busy = 0, o_prod = 0.
  - An in-flight operation is discarded.
- IDLE:
  - o_ready = 1.
  - On i_valid at the clock edge: mlpr_r <= i_mlpr; mlpd_r <= zero-extended i_mlpd; prod_r <= 0; cnt <= 0; go to MULT.
- MULT, each edge:
  - prod_r <= prod_r + sum over j in [0, STEP-1] of (mlpr_r[j] ? mlpd_r << j : 0), truncated to 2*WIDTH bits (no overflow possible).
  - mlpr_r <= mlpr_r >> STEP (zero fill).
  - mlpd_r <= mlpd_r << STEP.
  - cnt <= cnt + 1.
  - On the edge where cnt == NSTEPS-1: go to DONE.
- DONE:
  - o_valid = 1; o_prod is stable and prod_r is held.
  - On i_ready: go to IDLE. o_ready rises the following cycle; there is no same-cycle accept-while-draining.
  - i_valid is ignored outside IDLE; operands are not sampled.
- Latency: NSTEPS+1 clock edges from the accept edge to o_valid high (5 for 32/8). Throughput: one product per NSTEPS+2 cycles, given i_ready held high.
- STEP = WIDTH: NSTEPS = 1; a single MULT cycle.
- Zero operands: follow the normal path unless the optional feature is enabled.
- o_ready, o_valid and o_busy are decoded from state only; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: FLP_IMULT_SEQ_EARLY_EXIT_EN.
- Defined:
  - In MULT, if the post-shift mlpr_r value would be zero, go to DONE on that same edge.
  - In IDLE, if i_mlpr == 0 at accept, load prod_r = 0 and go directly to DONE.
  - Latency becomes data dependent, from 1 up to NSTEPS+1 edges.
- Undefined: fixed latency of NSTEPS+1 edges; the early-exit logic is absent.

Decomposition:
- Shared package flp_imult_pkg:
  - State enum: IDLE = 2'd0, MULT = 2'd1, DONE = 2'd2.
  - Helper for NSTEPS / counter width.
- Sub-module flp_imult_step (parameters WIDTH, STEP):
  - Purely combinational.
  - Inputs: STEP multiplier bits, 2*WIDTH shifted multiplicand, 2*WIDTH accumulator.
  - Output: new accumulator.
  - Instantiated once in flp_imult_seq.

Test Plan (WIDTH=32, STEP=8 unless noted):
- Basic: accept 3 x 5 -> o_valid exactly 5 edges after accept, o_prod = 64'd15, o_busy high throughout; with EARLY_EXIT_EN, o_valid after 2 edges.
- Max operands: 0xFFFFFFFF x 0xFFFFFFFF -> o_prod = 64'hFFFFFFFE00000001.
- Backpressure: hold i_ready = 0 for 10 cycles in DONE -> o_valid and o_prod stable; toggle i_valid and operands meanwhile -> no capture; release i_ready -> o_ready = 1 on the next cycle.
- Zero: 0 x 0x12345678 -> 0 after 5 edges; with EARLY_EXIT_EN, o_valid 1 edge after accept.
- Reset mid-MULT: assert rst asynchronously at cnt = 2 -> immediate IDLE, o_prod = 0, o_valid = 0; next operation 7 x 9 -> 63.
- Random back-to-back: 1000 random pairs, i_ready always 1, for STEP in {1, 4, 8, 32} -> every product matches a 64-bit reference model; cycle count per op = NSTEPS+2.
